// File: rtl/code39_pkg.sv
// Shared definitions for the Code 39 barcode decoder.
//   - state_e        : decoder FSM state encoding (also exported for debug)
//   - ERR_*          : err_code values
//   - START_STOP     : the '*' start/stop pattern
//   - code39_lookup  : 9-element pattern -> {hit, ASCII}
// Pattern bit 8 is element 0 (the first bar), bit 0 is element 8 (the last
// bar); a 1 marks a wide element, so literals read left to right as scanned.
package code39_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_QUIET    = 3'd1,
        ST_MEASURE  = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_DECODE   = 3'd4,
        ST_GAP      = 3'd5
    } state_e;

    localparam logic [1:0] ERR_OVERFLOW = 2'd0;
    localparam logic [1:0] ERR_PATTERN  = 2'd1;
    localparam logic [1:0] ERR_NO_START = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

    localparam logic [8:0] START_STOP = 9'b010010100;

    // Returns {1'b1, ascii} for a table hit, 9'h000 otherwise.
    function automatic logic [8:0] code39_lookup(input logic [8:0] pat);
        logic [8:0] r;
        r = 9'h000;
        case (pat)
            9'b000110100: r = {1'b1, "0"};
            9'b100100001: r = {1'b1, "1"};
            9'b001100001: r = {1'b1, "2"};
            9'b101100000: r = {1'b1, "3"};
            9'b000110001: r = {1'b1, "4"};
            9'b100110000: r = {1'b1, "5"};
            9'b001110000: r = {1'b1, "6"};
            9'b000100101: r = {1'b1, "7"};
            9'b100100100: r = {1'b1, "8"};
            9'b001100100: r = {1'b1, "9"};
            9'b100001001: r = {1'b1, "A"};
            9'b001001001: r = {1'b1, "B"};
            9'b101001000: r = {1'b1, "C"};
            9'b000011001: r = {1'b1, "D"};
            9'b100011000: r = {1'b1, "E"};
            9'b001011000: r = {1'b1, "F"};
            9'b000001101: r = {1'b1, "G"};
            9'b100001100: r = {1'b1, "H"};
            9'b001001100: r = {1'b1, "I"};
            9'b000011100: r = {1'b1, "J"};
            9'b100000011: r = {1'b1, "K"};
            9'b001000011: r = {1'b1, "L"};
            9'b101000010: r = {1'b1, "M"};
            9'b000010011: r = {1'b1, "N"};
            9'b100010010: r = {1'b1, "O"};
            9'b001010010: r = {1'b1, "P"};
            9'b000000111: r = {1'b1, "Q"};
            9'b100000110: r = {1'b1, "R"};
            9'b001000110: r = {1'b1, "S"};
            9'b000010110: r = {1'b1, "T"};
            9'b110000001: r = {1'b1, "U"};
            9'b011000001: r = {1'b1, "V"};
            9'b111000000: r = {1'b1, "W"};
            9'b010010001: r = {1'b1, "X"};
            9'b110010000: r = {1'b1, "Y"};
            9'b011010000: r = {1'b1, "Z"};
            9'b010000101: r = {1'b1, "-"};
            9'b110000100: r = {1'b1, "."};
            9'b011000100: r = {1'b1, " "};
            9'b010010100: r = {1'b1, "*"};
            9'b010101000: r = {1'b1, "$"};
            9'b010100010: r = {1'b1, "/"};
            9'b010001010: r = {1'b1, "+"};
            9'b000101010: r = {1'b1, "%"};
            default:      r = 9'h000;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/char_fifo.sv
// Synchronous FIFO for decoded characters.
//   clk, rst (sync, active-low)
//   push, push_data : write request (dropped when full unless a pop frees space)
//   pop             : read request, ignored when empty
//   head, valid     : head entry (8'h00 when empty) and non-empty flag
//   overflow        : high in the cycle a push is dropped
module char_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic       valid,
    output logic       overflow
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, do_push, do_pop;

    assign valid    = (count != '0);
    assign full     = (count == (AW+1)'(DEPTH));
    assign do_pop   = pop && valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign do_push  = push && (!full || do_pop);
    assign overflow = push && !do_push;
    assign head     = valid ? mem[rd_ptr] : 8'h00;

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/code39_decoder.sv
// Code 39 barcode decoder: measures bar/space run lengths from a sampled
// scanner line, classifies nine elements as narrow/wide, decodes them and
// queues the ASCII characters of a '*'-framed message.
//   clk, rst (sync, active-low), start (enable; low forces IDLE)
//   scan_bit               : 0 = bar, 1 = space
//   char_data/char_valid/char_ready : character stream. valid/ready handshake:
//       char_data is stable while char_valid is high; the head is consumed on
//       every rising edge where char_valid && char_ready; ready may be high
//       at any time and is ignored when valid is low.
//   msg_done : one-cycle pulse on the stop '*'
//   err, err_code : one-cycle error pulse and its cause
//   busy : FSM not in IDLE;  state_dbg : current FSM state
module code39_decoder
    import code39_pkg::*;
#(
    parameter int CNT_W      = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int QUIET_LEN  = 2000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       scan_bit,
    output logic [7:0] char_data,
    output logic       char_valid,
    input  logic       char_ready,
    output logic       msg_done,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy,
    output state_e     state_dbg
);
    localparam logic [CNT_W-1:0] QUIET_M1 = CNT_W'(QUIET_LEN - 1);

    state_e           state, state_n;
    logic             prev_bit;
    logic [CNT_W-1:0] run_cnt;
    logic [CNT_W-1:0] width [9];
    logic [3:0]       k;
    logic [8:0]       pattern_q, pat_c;
    logic [CNT_W-1:0] w_min;
    logic             first_char;
    logic             run_edge, run_full, space_to, sat_to;
    logic [8:0]       lookup;
    logic             push, fifo_overflow;
    logic             err_n, done_n;
    logic [1:0]       err_code_n;

    assign run_edge = (scan_bit != prev_bit);
    assign run_full = (run_cnt == '1);
    // Current cycle is the QUIET_LEN-th consecutive space sample.
    assign space_to = scan_bit && prev_bit && (run_cnt >= QUIET_M1);
    assign sat_to   = run_full && !run_edge;
    assign lookup   = code39_lookup(pattern_q);
    assign busy      = (state != ST_IDLE);
    assign state_dbg = state;

    // Narrow/wide classification against the narrowest of the nine elements.
    always_comb begin
        w_min = width[0];
        for (int i = 1; i < 9; i++) begin
            if (width[i] < w_min) w_min = width[i];
        end
        pat_c = '0;
        for (int i = 0; i < 9; i++) begin
            pat_c[8-i] = ({2'b00, width[i]} << 1) >=
                         ({2'b00, w_min} + {1'b0, w_min, 1'b0});
        end
    end

    always_comb begin
        state_n    = state;
        err_n      = 1'b0;
        err_code_n = ERR_OVERFLOW;
        done_n     = 1'b0;
        push       = 1'b0;
        case (state)
            ST_IDLE:     state_n = ST_QUIET;
            ST_QUIET:    if (!scan_bit) state_n = ST_MEASURE;
            ST_MEASURE: begin
                if (space_to || sat_to) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                    state_n    = ST_QUIET;
                end else if (run_edge && k == 4'd8) begin
                    state_n = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: state_n = ST_DECODE;
            ST_DECODE: begin
                if (!lookup[8] || $countones(pattern_q) != 3) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_PATTERN;
                    state_n    = ST_QUIET;
                end else if (first_char) begin
                    if (pattern_q == START_STOP) begin
                        state_n = ST_GAP;
                    end else begin
                        err_n      = 1'b1;
                        err_code_n = ERR_NO_START;
                        state_n    = ST_QUIET;
                    end
                end else if (pattern_q == START_STOP) begin
                    done_n  = 1'b1;
                    state_n = ST_QUIET;
                end else begin
                    push    = 1'b1;
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (space_to) begin
                    err_n      = 1'b1;
                    err_code_n = ERR_TIMEOUT;
                    state_n    = ST_QUIET;
                end else if (!scan_bit) begin
                    state_n = ST_MEASURE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
        // Dropping start abandons whatever is in flight.
        if (!start) begin
            state_n = ST_IDLE;
            err_n   = 1'b0;
            done_n  = 1'b0;
            push    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_IDLE;
            prev_bit   <= 1'b1;
            run_cnt    <= '0;
            k          <= '0;
            pattern_q  <= '0;
            first_char <= 1'b1;
            for (int i = 0; i < 9; i++) width[i] <= '0;
            msg_done   <= 1'b0;
            err        <= 1'b0;
            err_code   <= ERR_OVERFLOW;
        end else begin
            state    <= state_n;
            prev_bit <= scan_bit;
            // The run counter keeps going through CLASSIFY/DECODE so the
            // intercharacter space is timed from its real start.
            if (state == ST_IDLE || state_n == ST_IDLE)
                run_cnt <= '0;
            else if (run_edge || (state == ST_QUIET && !scan_bit))
                run_cnt <= CNT_W'(1);
            else if (!run_full)
                run_cnt <= run_cnt + CNT_W'(1);

            if (state == ST_MEASURE) begin
                if (run_edge) begin
                    width[k] <= run_cnt;
                    k        <= k + 4'd1;
                end
            end else begin
                k <= '0;
            end

            if (state == ST_CLASSIFY) pattern_q <= pat_c;

            if (state_n == ST_QUIET || state_n == ST_IDLE)
                first_char <= 1'b1;
            else if (state == ST_DECODE && state_n == ST_GAP)
                first_char <= 1'b0;

            msg_done <= done_n;
            err      <= err_n || fifo_overflow;
            err_code <= fifo_overflow ? ERR_OVERFLOW : err_code_n;
        end
    end

    char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (lookup[7:0]),
        .pop       (char_ready),
        .head      (char_data),
        .valid     (char_valid),
        .overflow  (fifo_overflow)
    );

endmodule
